register_file_array: RTL
========================

# register_file_array

Parametrised multi-port register file for the CPU datapath, built as the array-level successor to the single bit cell. It provides DEPTH words of WIDTH bits, one synchronous write port and NUM_RD independently enabled read ports. Each read port drives its bus to high-Z when not enabled, so ports can share a bus the way bit cell bitlines do. It adds same-cycle write-to-read bypass, an optional hardwired zero register, and a multi-cycle clear sweep with a busy indication.

## Interface
- WIDTH, 16: bits per register.
- DEPTH, 16: number of registers; AW = $clog2(DEPTH), minimum 1.
- NUM_RD, 2: number of read ports.
- ZERO_REG, 1: when 1, entry 0 always reads 0 and writes to it are dropped.
- BYPASS, 1: when 1, a same-cycle write to the addressed entry is forwarded to a read port.

- clk  in  1  clock; everything is sampled on its rising edge.
- rst  in  1  synchronous, active-high reset.
- WriteEnable  in  1  write strobe.
- WriteReg  in  AW  write address.
- WriteData  in  WIDTH  write data.
- ReadEnable  in  NUM_RD  per-port read enable.
- ReadReg  in  NUM_RD x AW  per-port read address.
- ReadData  out  NUM_RD x WIDTH  per-port read data; 'z when the port is disabled.
- ClearReq  in  1  start a clear sweep (single-cycle pulse or level).
- Busy  out  1  high while a clear sweep is in progress.

## Operation
- Reset (rst=1 at an edge):
  - All entries become 0.
  - FSM goes to IDLE, sweep counter goes to 0, Busy=0.
  - Reset wins over every other input in the same cycle.
- Write acceptance: the write takes effect at the edge only when all of these hold:
  - WriteEnable=1
  - Busy=0
  - WriteReg < DEPTH
  - not (ZERO_REG and WriteReg==0)
- Read port i (combinational):
  - ReadEnable[i]=0: ReadData[i] = 'z.
  - Otherwise, the first matching rule applies:
    1. ReadReg[i] >= DEPTH: 0.
    2. ZERO_REG and ReadReg[i]==0: 0.
    3. BYPASS, the write is accepted this cycle, and WriteReg==ReadReg[i]: WriteData.
    4. Otherwise: the stored entry.
- Ports are fully independent. Several ports may read the same address in the same cycle.
- Clear FSM has two states, IDLE and SWEEP:
  - IDLE -> SWEEP when ClearReq=1 at an edge. Counter is loaded with 0.
  - In SWEEP, each edge writes 0 to entry[counter], then the counter increments.
  - SWEEP -> IDLE at the edge that clears entry DEPTH-1.
  - ClearReq is ignored while in SWEEP.
- During SWEEP:
  - All external writes are dropped and bypass is suppressed.
  - Reads return the current array contents: entries not yet swept still hold their old values.
- ClearReq and WriteEnable asserted in the same IDLE cycle: the write is accepted on that edge, and the sweep then zeroes that entry.

## Timing
- Read latency is 0 cycles (combinational). Write latency is 1 edge.
- A value written at edge N is readable from the array after edge N. With BYPASS=1 it is also visible in the same cycle as the write.
- Busy rises 1 cycle after ClearReq is sampled in IDLE. It stays high for exactly DEPTH cycles, then falls.
- The first write accepted after a sweep is the one presented in the cycle where Busy=0 again.
- Reset mid-sweep: at the next edge all entries are 0 and the FSM is IDLE; the sweep does not resume.
- Counter width is AW+1 bits so that DEPTH = 2^AW terminates without wrap.

## Structure
- Shared package reg_pkg holds:
  - the FSM state enum {IDLE, SWEEP};
  - a clog2-based address-width helper.
- One natural sub-module: register_file_readport, the per-port mux, bypass and tri-state driver, instantiated NUM_RD times with a generate loop.
- Storage, write logic and the clear FSM live in the top module.

## Test plan
- Reset, then write 0xBEEF to r3 and read r3 on both ports next cycle -> both ReadData = 0xBEEF. With ReadEnable=0 -> ReadData = 'z.
- Bypass: write 0x1234 to r5 while port 0 reads r5 in the same cycle -> ReadData[0] = 0x1234 in that cycle. With BYPASS=0 -> old value (0).
- ZERO_REG=1: write 0xFFFF to r0 -> r0 reads 0 on every port.
- Fill all 16 entries with nonzero values, pulse ClearReq:
  - Busy is high for exactly 16 cycles.
  - A write to r7 during the sweep is dropped.
  - After Busy falls, all entries read 0.
  - Mid-sweep, r15 still reads its old value.
- Assert rst at sweep cycle 4 -> next cycle Busy=0 and all entries read 0. A write to r2 on the following cycle succeeds.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared types and helpers for the register file array.
package reg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

  // Address width for a given depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/register_file_readport.sv
// One read port: range check, zero register, write bypass, then array lookup.
module register_file_readport #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] mem_i,
  input  logic                        wr_acc_i,
  input  logic [AW-1:0]               wr_addr_i,
  input  logic [WIDTH-1:0]            wr_data_i,
  input  logic [AW-1:0]               rd_addr_i,
  output logic [WIDTH-1:0]            rd_data_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Priority: out of range, hardwired zero, same-cycle forward, stored value.
  always_comb begin
    rd_data_o = '0;
    if ({1'b0, rd_addr_i} >= DEPTH_C) begin
      rd_data_o = '0;
    end else if (ZERO_REG && (rd_addr_i == '0)) begin
      rd_data_o = '0;
    end else if (BYPASS && wr_acc_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_o = wr_data_i;
    end else begin
      rd_data_o = mem_i[rd_addr_i];
    end
  end

endmodule

// File: rtl/register_file_array.sv
// Multi-port register file with write bypass, optional zero register and
// a one-entry-per-cycle clear sweep.
module register_file_array
  import reg_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = addr_w(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         WriteEnable,
  input  logic [AW-1:0]                WriteReg,
  input  logic [WIDTH-1:0]             WriteData,
  input  logic [NUM_RD-1:0]            ReadEnable,
  input  logic [NUM_RD-1:0][AW-1:0]    ReadReg,
  output logic [NUM_RD-1:0][WIDTH-1:0] ReadData,
  input  logic                         ClearReq,
  output logic                         Busy
);

  // One extra counter bit so a power-of-two depth ends without wrapping.
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  clr_state_e                  state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        wr_acc;

  // External writes only land when idle, in range and not aimed at r0.
  assign wr_acc = WriteEnable && (state_q == IDLE) &&
                  ({1'b0, WriteReg} < DEPTH_C) &&
                  !(ZERO_REG && (WriteReg == '0));

  assign Busy = (state_q == SWEEP);

  // Clear FSM next state: sweep starts at entry 0, ends after DEPTH-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ClearReq) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DEPTH_C - 1'b1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear FSM state and sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage: external write when idle, one zeroed entry per sweep cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      if (wr_acc) mem_q[WriteReg] <= WriteData;
      if (state_q == SWEEP) mem_q[cnt_q[AW-1:0]] <= '0;
    end
  end

  // Per-port lookup plus tri-state drive onto the shared read bus.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [WIDTH-1:0] rd_data;

    register_file_readport #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .AW      (AW),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_port (
      .mem_i    (mem_q),
      .wr_acc_i (wr_acc),
      .wr_addr_i(WriteReg),
      .wr_data_i(WriteData),
      .rd_addr_i(ReadReg[g]),
      .rd_data_o(rd_data)
    );

    assign ReadData[g] = ReadEnable[g] ? rd_data : {WIDTH{1'bz}};
  end

endmodule
